// File: rtl/fir_pkg.sv
// Shared definitions for the FIR stream datapath: arbiter FSM states, the
// channel-index width helper and the default sample width used by the FIR wrapper.
package fir_pkg;

  localparam int FIR_DATA_W = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_t;

  // At least one bit so a single-channel index is still a legal vector.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_stream_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first requester found scanning
// rr_ptr+1, rr_ptr+2, ... modulo N_CH.
module rr_pick
  import fir_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int i = 1; i <= N_CH; i++) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(N_CH)) sum = sum - (IDX_W+1)'(N_CH);
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fir_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding the shared FIR slave port; tags each
// packet with its source index and force-terminates packets longer than max_beats.
module fir_stream_arbiter
  import fir_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = FIR_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic                        s00_axis_aclk,
  input  logic                        s00_axis_aresetn,
  input  logic [N_CH*DATA_W-1:0]      s_axis_tdata,
  input  logic [N_CH-1:0]             s_axis_tvalid,
  input  logic [N_CH-1:0]             s_axis_tlast,
  output logic [N_CH-1:0]             s_axis_tready,
  output logic [DATA_W-1:0]           m00_axis_tdata,
  output logic                        m00_axis_tvalid,
  output logic                        m00_axis_tlast,
  input  logic                        m00_axis_tready,
  output logic [ch_idx_w(N_CH)-1:0]   m00_axis_tuser,
  input  logic [CNT_W-1:0]            max_beats,
  output logic                        busy,
  output logic [N_CH-1:0]             trunc_err,
  input  logic                        err_clr,
  output arb_state_t                  state_dbg
);

  localparam int IDX_W = ch_idx_w(N_CH);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_q, rr_ptr_q, pick_idx;
  logic [CNT_W-1:0] beat_cnt_q, lim_q;
  logic [N_CH-1:0]  trunc_err_q, trunc_vec;
  logic             pick_found, xfer, src_valid, src_last, lim_hit;
  logic             accept, last_beat, trunc_set;
  logic [DATA_W-1:0] src_data;

  rr_pick #(.N_CH(N_CH), .IDX_W(IDX_W)) u_rr_pick (
    .req    (s_axis_tvalid),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  // Handshake: a beat moves when tvalid & tready are both high at the clock edge;
  // tvalid/tdata/tlast/tuser never depend on tready and hold while stalled.
  always_comb begin
    xfer      = (state_q == ST_XFER);
    src_valid = s_axis_tvalid[grant_q];
    src_last  = s_axis_tlast[grant_q];
    src_data  = s_axis_tdata[int'(grant_q)*DATA_W +: DATA_W];
    lim_hit   = (lim_q != '0) && (beat_cnt_q == lim_q - CNT_W'(1));

    m00_axis_tvalid = xfer & src_valid;
    m00_axis_tdata  = xfer ? src_data : '0;
    m00_axis_tuser  = xfer ? grant_q : '0;
    m00_axis_tlast  = m00_axis_tvalid & (src_last | lim_hit);
    s_axis_tready   = '0;
    if (xfer) s_axis_tready[grant_q] = m00_axis_tready;

    accept    = m00_axis_tvalid & m00_axis_tready;
    last_beat = accept & (src_last | lim_hit);
    trunc_set = accept & lim_hit & ~src_last;
    trunc_vec = '0;
    if (trunc_set) trunc_vec[grant_q] = 1'b1;

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_found) state_d = ST_XFER;
      ST_XFER: if (last_beat)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= IDX_W'(N_CH - 1);
      beat_cnt_q  <= '0;
      lim_q       <= '0;
      trunc_err_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && pick_found) begin
        grant_q    <= pick_idx;
        lim_q      <= max_beats;
        beat_cnt_q <= '0;
      end else if (accept && beat_cnt_q != '1) begin
        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      end
      if (last_beat) rr_ptr_q <= grant_q;
      // A truncation landing with err_clr keeps its flag.
      trunc_err_q <= (err_clr ? '0 : trunc_err_q) | trunc_vec;
    end
  end

  assign busy      = xfer;
  assign trunc_err = trunc_err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fir_stream_arbiter.sv
// Directed bench for fir_stream_arbiter: queue-driven AXIS sources, a negedge
// monitor with an expected-beat scoreboard, and hand-computed packet tables.
module tb_fir_stream_arbiter;
  import fir_pkg::*;

  localparam int N_CH = 4;
  localparam int DW   = 64;
  localparam int CW   = 16;
  localparam int IW   = 2;
  localparam int EW   = DW + IW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N_CH*DW-1:0] s_tdata = '0;
  logic [N_CH-1:0]    s_tvalid = '0;
  logic [N_CH-1:0]    s_tlast = '0;
  logic [N_CH-1:0]    s_tready;
  logic [DW-1:0]      m_data;
  logic               m_valid, m_last;
  logic               m_ready = 1'b1;
  logic [IW-1:0]      m_user;
  logic [CW-1:0]      max_beats = '0;
  logic               busy;
  logic [N_CH-1:0]    trunc_err;
  logic               err_clr = 1'b0;
  arb_state_t         state_dbg;

  fir_stream_arbiter #(.N_CH(N_CH), .DATA_W(DW), .CNT_W(CW)) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s_axis_tdata     (s_tdata),
    .s_axis_tvalid    (s_tvalid),
    .s_axis_tlast     (s_tlast),
    .s_axis_tready    (s_tready),
    .m00_axis_tdata   (m_data),
    .m00_axis_tvalid  (m_valid),
    .m00_axis_tlast   (m_last),
    .m00_axis_tready  (m_ready),
    .m00_axis_tuser   (m_user),
    .max_beats        (max_beats),
    .busy             (busy),
    .trunc_err        (trunc_err),
    .err_clr          (err_clr),
    .state_dbg        (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW:0]   src_q[N_CH][$];
  logic [N_CH-1:0] hs = '0;
  bit  rand_ready = 0;
  int  neg_cyc = 0, acc_cnt = 0, busy_cnt = 0, rdy2_cnt = 0;
  int  v_cyc = -1, a_cyc = -1;
  bit  watch = 0, gap_en = 0, gap_have = 0, gap_prev_last = 0;
  int  gap_prev_cyc = 0;
  bit  held_pend = 0;
  logic [DW-1:0] held = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_src(input int ch, input logic [DW-1:0] base, input int len);
    for (int b = 1; b <= len; b++) src_q[ch].push_back({(b == len), base + DW'(b)});
  endtask

  task automatic push_exp(input int ch, input logic [DW-1:0] data, input logic last);
    exp_q.push_back({last, IW'(ch), data});
  endtask

  function automatic bit src_pending();
    for (int k = 0; k < N_CH; k++) if (src_q[k].size() != 0) return 1;
    return 0;
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || src_pending()) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_acc(input int target, input int budget);
    int n = 0;
    while (acc_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("accept_wait", acc_cnt, target);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Sources: present queue head, pop it after each handshake.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < N_CH; k++) begin
      if (hs[k] && src_q[k].size() != 0) void'(src_q[k].pop_front());
      if (src_q[k].size() != 0) begin
        s_tvalid[k] = 1'b1;
        s_tdata[k*DW +: DW] = src_q[k][0][DW-1:0];
        s_tlast[k] = src_q[k][0][DW];
      end else begin
        s_tvalid[k] = 1'b0;
        s_tlast[k]  = 1'b0;
      end
    end
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: sampled mid-cycle, a beat is accepted when valid & ready here.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    neg_cyc++;
    hs = s_tvalid & s_tready;
    if (!rst_n) begin
      held_pend = 0;
    end else begin
      if (held_pend) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, held);
      end
      held_pend = m_valid && !m_ready;
      held = m_data;
      if (busy) busy_cnt++;
      if (s_tready[2]) rdy2_cnt++;
      if (watch && v_cyc < 0 && s_tvalid[2]) v_cyc = neg_cyc;
      if (m_valid && m_ready) begin
        acc_cnt++;
        if (watch && a_cyc < 0) a_cyc = neg_cyc;
        if (exp_q.size() == 0) begin
          check("extra_beat", {1'b1, m_last, m_user, m_data}, '0);
        end else begin
          e = exp_q.pop_front();
          check("beat", {m_last, m_user, m_data}, e);
        end
        if (gap_en) begin
          if (gap_have) check("gap", neg_cyc - gap_prev_cyc, gap_prev_last ? 2 : 1);
          gap_have = 1;
          gap_prev_cyc = neg_cyc;
          gap_prev_last = m_last;
        end
      end
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    int a0;
    repeat (2) @(negedge clk);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_data", m_data, 0);
    check("rst_user", m_user, 0);
    check("rst_ready", s_tready, 0);
    check("rst_busy", busy, 0);
    check("rst_trunc", trunc_err, 0);
    check("rst_state", state_dbg, ST_IDLE);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_state", state_dbg, ST_IDLE);

    // ch2 alone, 3-beat packet
    watch = 1; busy_cnt = 0; rdy2_cnt = 0;
    push_src(2, 64'h200, 3);
    for (int b = 1; b <= 3; b++) push_exp(2, 64'h200 + DW'(b), (b == 3));
    wait_idle(50);
    check("t1_busy_cycles", busy_cnt, 3);
    check("t1_ch2_ready_cycles", rdy2_cnt, 3);
    check("t1_first_accept_latency", a_cyc - v_cyc, 1);
    watch = 0;

    // all four channels, two 2-beat packets each: order 0,1,2,3,0,1,2,3
    do_reset();
    gap_en = 1; gap_have = 0;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < N_CH; k++) begin
        push_src(k, DW'(k*256 + p*16), 2);
        push_exp(k, DW'(k*256 + p*16 + 1), 1'b0);
        push_exp(k, DW'(k*256 + p*16 + 2), 1'b1);
      end
    wait_idle(200);
    gap_en = 0;

    // max_beats=4 truncates a 6-beat ch1 packet into 4 + 2
    max_beats = 16'd4;
    a0 = acc_cnt;
    push_src(1, 64'h300, 6);
    for (int b = 1; b <= 6; b++) push_exp(1, 64'h300 + DW'(b), (b == 4) || (b == 6));
    wait_acc(a0 + 4, 50);
    #2;
    check("t3_trunc_set", trunc_err, 4'b0010);
    check("t3_bubble_idle", busy, 0);
    wait_idle(50);
    check("t3_trunc_sticky", trunc_err, 4'b0010);
    max_beats = '0;
    @(posedge clk); #2 err_clr = 1'b1;
    @(posedge clk); #2 err_clr = 1'b0;
    check("t3_err_clr", trunc_err, 0);

    // ch3 under random downstream backpressure
    rand_ready = 1;
    push_src(3, 64'h400, 5);
    push_src(3, 64'h410, 3);
    for (int b = 1; b <= 5; b++) push_exp(3, 64'h400 + DW'(b), (b == 5));
    for (int b = 1; b <= 3; b++) push_exp(3, 64'h410 + DW'(b), (b == 3));
    wait_idle(300);
    rand_ready = 0;

    // set a flag and move rr_ptr to 1, then reset in the middle of a ch1 packet
    max_beats = 16'd1;
    push_src(1, 64'h500, 2);
    push_exp(1, 64'h501, 1'b1);
    push_exp(1, 64'h502, 1'b1);
    wait_idle(50);
    check("t5_trunc_pre", trunc_err, 4'b0010);
    max_beats = '0;
    a0 = acc_cnt;
    push_src(1, 64'h510, 5);
    push_exp(1, 64'h511, 1'b0);
    wait_acc(a0 + 1, 50);
    #2 rst_n = 1'b0;
    for (int k = 0; k < N_CH; k++) src_q[k].delete();
    @(negedge clk);
    check("t5_rst_valid", m_valid, 0);
    check("t5_rst_last", m_last, 0);
    check("t5_rst_data", m_data, 0);
    check("t5_rst_user", m_user, 0);
    check("t5_rst_ready", s_tready, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_trunc", trunc_err, 0);
    check("t5_rst_state", state_dbg, ST_IDLE);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < N_CH; k++) begin
      push_src(k, DW'(64'h600 + k*16), 1);
      push_exp(k, DW'(64'h600 + k*16 + 1), 1'b1);
    end
    wait_idle(100);

    check("end_exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_stream_arbiter.md
# fir_stream_arbiter

Packet-granular round-robin arbiter that time-shares the single AXI-Stream FIR datapath among up to `N_CH` independent sample sources. Sits directly upstream of the FIR wrapper's slave port. Grants one source at a time for a whole packet (until `tlast`) and tags the forwarded stream with the source index. Enforces a runtime maximum packet length so a stuck source cannot starve the others.

## Interface
Parameters:
- `N_CH`, 4: number of requesting streams (2..8).
- `DATA_W`, 64: per-stream TDATA width; matches FIR slave width.
- `CNT_W`, 16: width of beat counter and `max_beats`.

Ports:
- `s00_axis_aclk`, in, 1: sole clock.
- `s00_axis_aresetn`, in, 1: asynchronous, active-low reset.
- `s_axis_tdata`, in, `N_CH*DATA_W`: packed source data; channel k at bits `[k*DATA_W +: DATA_W]`.
- `s_axis_tvalid`, in, `N_CH`: per-source valid.
- `s_axis_tlast`, in, `N_CH`: per-source end of packet.
- `s_axis_tready`, out, `N_CH`: per-source ready.
- `m00_axis_tdata`, out, `DATA_W`: to FIR slave.
- `m00_axis_tvalid`, out, 1.
- `m00_axis_tlast`, out, 1.
- `m00_axis_tready`, in, 1: from FIR slave.
- `m00_axis_tuser`, out, `$clog2(N_CH)`: index of the granted source.
- `max_beats`, in, `CNT_W`: packet length limit. 0 means unlimited. Sampled at grant time.
- `busy`, out, 1: high in XFER.
- `trunc_err`, out, `N_CH`: sticky per-channel flag, set when that channel's packet was force-terminated.
- `err_clr`, in, 1: synchronous clear of `trunc_err`, one pulse.

## Operation
- FSM states:
  - IDLE: no grant held.
  - XFER: one source granted.
- Registers: `grant` (index), `rr_ptr` (last granted index), `beat_cnt`, `lim` (latched `max_beats`).
- IDLE:
  - All `s_axis_tready` = 0 and `m00_axis_tvalid` = 0.
  - If any `s_axis_tvalid` is high, pick the first requesting index scanning `rr_ptr+1, rr_ptr+2, …` modulo `N_CH`.
  - Register that index into `grant`, set `lim` ← `max_beats`, set `beat_cnt` ← 0, go to XFER.
- XFER (combinational pass-through, no data register):
  - `m00_axis_tdata`/`tvalid` = granted channel's data/valid.
  - `s_axis_tready[grant]` = `m00_axis_tready`; all other readies = 0.
  - `m00_axis_tuser` = `grant`.
- Beat accounting:
  - A beat is accepted when `m00_axis_tvalid & m00_axis_tready`.
  - Each accepted beat increments `beat_cnt`. It saturates; it does not wrap.
- Final beat: an accepted beat where the source `tlast` = 1, OR `lim` ≠ 0 and `beat_cnt == lim-1`.
  - `m00_axis_tlast` = 1 on a final beat, 0 otherwise.
  - On the final beat: `rr_ptr` ← `grant`, go to IDLE.
- Forced termination: if the beat is final only because of `lim`, set `trunc_err[grant]`. The source's remaining beats form a new packet at its next grant.
- If `err_clr` and a truncation set occur in the same cycle, set wins.
- Source `tvalid` deasserting mid-packet is legal: the grant is held indefinitely. No timeout.
- `max_beats` changes during XFER have no effect until the next grant.
- FIR filter history is not flushed between channels. Downstream handles this; it is out of scope here.

## Timing
- Reset values (async assert, sync deassert externally):
  - State IDLE, `grant` = 0, `rr_ptr` = `N_CH-1` (so channel 0 wins first), `beat_cnt` = 0, `lim` = 0, `trunc_err` = 0.
  - All outputs low.
- Data latency: 0 cycles. Master outputs are combinational from the granted source in XFER.
- Arbitration costs exactly 1 bubble cycle between packets: the final beat is accepted in cycle t, the IDLE decision happens in cycle t+1, and the next grant's first beat can be accepted in cycle t+2.
- `m00_axis_tvalid` never depends on `m00_axis_tready` (AXIS rule).
- A source that raises `tvalid` in the IDLE cycle is eligible in that same cycle.
- Reset mid-packet: return to IDLE immediately. The partial packet is abandoned and no `tlast` is generated.
- Single requester: it is re-granted after each 1-cycle bubble.

## Structure
- Shared package `fir_pkg`:
  - FSM state enum (`ST_IDLE`, `ST_XFER`).
  - Channel-index width function.
  - `DATA_W` default shared with the FIR wrapper.
- One sub-module, `rr_pick`: combinational round-robin priority encoder. Inputs are the request vector and `rr_ptr`; outputs are `found` and `idx`.
- Top level holds the FSM, counters, muxing and error flags.

## Test plan
- Reset, then ch2 sends a 3-beat packet with `tready`=1:
  - `tuser`=2 on all beats, `tlast` on beat 3, `busy` high 3 cycles.
  - ch2 `tready` high on exactly 3 cycles; first beat accepted 1 cycle after `tvalid` rises.
- ch0–ch3 all continuously valid with 2-beat packets: grant order 0,1,2,3,0,… with a 1-cycle gap between packets.
- `max_beats`=4 while ch1 sends a 6-beat packet:
  - Beats 1–4 are forwarded, with `tlast` on beat 4 and `trunc_err[1]`=1.
  - The next ch1 grant forwards beats 5–6 with a real `tlast`.
  - An `err_clr` pulse then clears the flag.
- Random `m00_axis_tready` backpressure on ch3: data is stable while `tvalid` is high and not ready, and no beat is dropped or duplicated (scoreboard vs source).
- Assert `aresetn`=0 on beat 2 of a 5-beat packet:
  - Next cycle all outputs are 0, `trunc_err`=0, state is IDLE.
  - After release, ch0 is granted first when all channels request.
